// File: rtl/axi2ahb_wr_buf_if.sv
// AXI W/B plus AHB write-data-phase signal bundle for axi2ahb_wr_buf.
// slave = buffer side, master = the AXI/AHB agents driving it.
interface axi2ahb_wr_buf_if #(
  parameter int DATA_BITS = 32,
  parameter int ID_BITS   = 4,
  parameter int CNT_BITS  = 3
);
  logic [ID_BITS-1:0]     WID;
  logic [DATA_BITS-1:0]   WDATA;
  logic [DATA_BITS/8-1:0] WSTRB;
  logic                   WLAST;
  logic                   WVALID;
  logic                   WREADY;
  logic [ID_BITS-1:0]     BID;
  logic [1:0]             BRESP;
  logic                   BVALID;
  logic                   BREADY;
  logic [DATA_BITS-1:0]   HWDATA;
  logic [DATA_BITS/8-1:0] HWSTRB;
  logic                   HREADY;
  logic                   HRESP;
  logic                   cmd_err;
  logic                   wdata_phase;
  logic                   data_last;
  logic                   wdata_ready;
  logic [CNT_BITS-1:0]    burst_cnt;

  modport slave (
    input  WID, WDATA, WSTRB, WLAST, WVALID,
    input  BREADY, HREADY, HRESP, cmd_err,
    input  wdata_phase, data_last,
    output WREADY, BID, BRESP, BVALID,
    output HWDATA, HWSTRB, wdata_ready, burst_cnt
  );

  modport master (
    output WID, WDATA, WSTRB, WLAST, WVALID,
    output BREADY, HREADY, HRESP, cmd_err,
    output wdata_phase, data_last,
    input  WREADY, BID, BRESP, BVALID,
    input  HWDATA, HWSTRB, wdata_ready, burst_cnt
  );
endinterface

// File: rtl/axi2ahb_wr_buf.sv
// AXI-to-AHB write buffer: data/strobe FIFO, per-burst ID and B response FIFOs.
// Ports: clk, reset (sync, active-high), bus (axi2ahb_wr_buf_if.slave).
module axi2ahb_wr_buf_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             do_pop;

  assign do_pop = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push)   wp <= wp + ONE;
      if (do_pop) rp <= rp + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end

  assign empty = (wp == rp);
  assign full  = (wp[AW-1:0] == rp[AW-1:0])
               & (wp[AW] != rp[AW]);
  // Empty head reads as zero so outputs are clean after reset.
  assign dout  = empty ? '0 : mem[rp[AW-1:0]];
endmodule

module axi2ahb_wr_buf #(
  parameter int         DATA_BITS   = 32,
  parameter int         ID_BITS     = 4,
  parameter int         FIFO_LINES  = 32,
  parameter int         CMD_DEPTH   = 4,
  parameter logic [1:0] RESP_SLVERR = 2'b10,
  parameter bit         STRB_EN     = 1'b1
) (
  input logic              clk,
  input logic              reset,
  axi2ahb_wr_buf_if.slave  bus
);
  localparam int SW = DATA_BITS / 8;
  localparam int CW = $clog2(CMD_DEPTH) + 1;
  localparam int DW = STRB_EN ? DATA_BITS + SW : DATA_BITS;
  localparam logic [CW-1:0] CMAX = CW'(CMD_DEPTH);
  localparam logic [CW-1:0] ONE  = 1;

  logic          wready;
  logic          push;
  logic          axi_last;
  logic          pop;
  logic          ahb_last;
  logic          data_full;
  logic          data_empty;
  logic          id_full;
  logic          id_empty;
  logic          resp_full;
  logic          resp_empty;
  logic [CW-1:0] cnt;
  logic          err_acc;
  logic [1:0]    resp;

  logic [DW-1:0]        d_in;
  logic [DW-1:0]        d_out;
  logic [ID_BITS-1:0]   id_head;
  logic [ID_BITS+1:0]   r_in;
  logic [ID_BITS+1:0]   r_out;

  assign wready   = ~data_full & (cnt < CMAX) & ~id_full;
  assign push     = bus.WVALID & wready;
  assign axi_last = push & bus.WLAST;
  assign pop      = bus.wdata_phase & bus.HREADY;
  assign ahb_last = pop & bus.data_last;

  if (STRB_EN) begin : g_strb
    assign d_in       = {bus.WSTRB, bus.WDATA};
    assign bus.HWSTRB = d_out[DW-1:DATA_BITS];
  end else begin : g_nostrb
    logic unused_strb;
    assign unused_strb = ^bus.WSTRB;
    assign d_in        = bus.WDATA;
    assign bus.HWSTRB  = '1;
  end

  axi2ahb_wr_buf_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_LINES)
  ) u_data (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (d_in),
    .pop   (pop),
    .dout  (d_out),
    .empty (data_empty),
    .full  (data_full)
  );

  axi2ahb_wr_buf_fifo #(
    .WIDTH (ID_BITS),
    .DEPTH (CMD_DEPTH)
  ) u_id (
    .clk   (clk),
    .reset (reset),
    .push  (axi_last),
    .din   (bus.WID),
    .pop   (ahb_last),
    .dout  (id_head),
    .empty (id_empty),
    .full  (id_full)
  );

  // The last beat's own error counts toward this burst's response.
  assign resp = (err_acc | bus.HRESP | bus.cmd_err)
              ? RESP_SLVERR : 2'b00;
  assign r_in = {resp, id_head};

  axi2ahb_wr_buf_fifo #(
    .WIDTH (ID_BITS + 2),
    .DEPTH (CMD_DEPTH)
  ) u_resp (
    .clk   (clk),
    .reset (reset),
    .push  (ahb_last),
    .din   (r_in),
    .pop   (bus.BREADY),
    .dout  (r_out),
    .empty (resp_empty),
    .full  (resp_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (axi_last & ~ahb_last) begin
      cnt <= cnt + ONE;
    end else if (ahb_last & ~axi_last) begin
      cnt <= cnt - ONE;
    end
  end

  // Clear on burst end wins over a same-cycle set.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_acc <= 1'b0;
    end else if (ahb_last) begin
      err_acc <= 1'b0;
    end else if (pop & (bus.HRESP | bus.cmd_err)) begin
      err_acc <= 1'b1;
    end
  end

  logic unused_empty;
  assign unused_empty = data_empty ^ id_empty;

  assign bus.WREADY      = wready;
  assign bus.HWDATA      = d_out[DATA_BITS-1:0];
  assign bus.BVALID      = ~resp_empty;
  assign bus.BID         = r_out[ID_BITS-1:0];
  assign bus.BRESP       = r_out[ID_BITS+:2];
  assign bus.wdata_ready = (cnt != '0) & ~resp_full;
  assign bus.burst_cnt   = cnt;
endmodule

// File: tb/tb_axi2ahb_wr_buf.sv
// Bench for axi2ahb_wr_buf: directed scenarios then random traffic,
// compared every cycle against a queue-based reference model.
module tb_axi2ahb_wr_buf;
  localparam int DB = 32;
  localparam int IB = 4;
  localparam int FL = 32;
  localparam int CD = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi2ahb_wr_buf_if #(.DATA_BITS(DB), .ID_BITS(IB), .CNT_BITS(CW)) b ();
  axi2ahb_wr_buf_if #(.DATA_BITS(DB), .ID_BITS(IB), .CNT_BITS(CW)) b2 ();

  axi2ahb_wr_buf #(
    .DATA_BITS(DB), .ID_BITS(IB), .FIFO_LINES(FL),
    .CMD_DEPTH(CD), .RESP_SLVERR(2'b10), .STRB_EN(1'b1)
  ) dut (.clk(clk), .reset(reset), .bus(b.slave));

  axi2ahb_wr_buf #(
    .DATA_BITS(DB), .ID_BITS(IB), .FIFO_LINES(FL),
    .CMD_DEPTH(CD), .RESP_SLVERR(2'b10), .STRB_EN(1'b0)
  ) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));

  assign b2.WID         = b.WID;
  assign b2.WDATA       = b.WDATA;
  assign b2.WSTRB       = b.WSTRB;
  assign b2.WLAST       = b.WLAST;
  assign b2.WVALID      = b.WVALID;
  assign b2.BREADY      = b.BREADY;
  assign b2.HREADY      = b.HREADY;
  assign b2.HRESP       = b.HRESP;
  assign b2.cmd_err     = b.cmd_err;
  assign b2.wdata_phase = b.wdata_phase;
  assign b2.data_last   = b.data_last;

  typedef struct {
    logic [DB-1:0] d;
    logic [3:0]    s;
  } beat_t;

  beat_t         dq[$];
  logic [IB-1:0] idq[$];
  int            lenq[$];
  logic [IB+1:0] rq[$];
  int            cur_len;
  int            head_done;
  bit            err;
  int            vecs;
  int            errs;

  function automatic bit m_wready();
    return dq.size() < FL && lenq.size() < CD;
  endfunction

  function automatic bit m_wdrdy();
    return lenq.size() != 0 && rq.size() < CD;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    dq.delete();
    idq.delete();
    lenq.delete();
    rq.delete();
    cur_len   = 0;
    head_done = 0;
    err       = 1'b0;
  endtask

  task automatic cyc();
    bit            wr;
    bit            pop;
    bit            bv;
    logic [DB-1:0] ed;
    logic [3:0]    es;
    logic [IB-1:0] eid;
    logic [1:0]    er;
    logic [IB-1:0] hid;
    wr  = m_wready();
    ed  = '0;
    es  = '0;
    eid = '0;
    er  = '0;
    if (dq.size() != 0) begin
      ed = dq[0].d;
      es = dq[0].s;
    end
    if (rq.size() != 0) begin
      eid = rq[0][IB-1:0];
      er  = rq[0][IB+1:IB];
    end
    chk("WREADY", b.WREADY, wr);
    chk("burst_cnt", b.burst_cnt, lenq.size());
    chk("wdata_ready", b.wdata_ready, m_wdrdy());
    chk("BVALID", b.BVALID, rq.size() != 0);
    chk("BID", b.BID, eid);
    chk("BRESP", b.BRESP, er);
    chk("HWDATA", b.HWDATA, ed);
    chk("HWSTRB", b.HWSTRB, es);
    chk("HWDATA_nostrb", b2.HWDATA, ed);
    chk("HWSTRB_nostrb", b2.HWSTRB, 4'hF);
    pop = b.wdata_phase && b.HREADY;
    bv  = rq.size() != 0;
    @(posedge clk);
    if (reset) begin
      m_clear();
    end else begin
      if (bv && b.BREADY) void'(rq.pop_front());
      if (pop) begin
        void'(dq.pop_front());
        if (b.data_last) begin
          hid = idq.pop_front();
          rq.push_back({(err || b.HRESP || b.cmd_err) ? 2'b10 : 2'b00, hid});
          void'(lenq.pop_front());
          err       = 1'b0;
          head_done = 0;
        end else begin
          head_done++;
          if (b.HRESP || b.cmd_err) err = 1'b1;
        end
      end
      if (wr && b.WVALID) begin
        dq.push_back('{b.WDATA, b.WSTRB});
        cur_len++;
        if (b.WLAST) begin
          idq.push_back(b.WID);
          lenq.push_back(cur_len);
          cur_len = 0;
        end
      end
    end
    #1;
  endtask

  task automatic w(bit v, logic [IB-1:0] id, logic [DB-1:0] d,
                   logic [3:0] s, bit l);
    b.WVALID = v;
    b.WID    = id;
    b.WDATA  = d;
    b.WSTRB  = s;
    b.WLAST  = l;
  endtask

  // Enter a data phase only mid-burst or when a whole burst may start.
  task automatic h(bit en, bit hr, bit he, bit ce);
    b.HREADY = hr;
    if (en && (head_done > 0 || m_wdrdy())) begin
      b.wdata_phase = 1'b1;
      b.HRESP       = he;
      b.cmd_err     = ce;
      b.data_last   = (head_done + 1 == lenq[0]);
    end else begin
      b.wdata_phase = 1'b0;
      b.HRESP       = 1'b0;
      b.cmd_err     = 1'b0;
      b.data_last   = 1'b0;
    end
  endtask

  initial begin
    vecs  = 0;
    errs  = 0;
    reset = 1'b1;
    b.BREADY = 1'b0;
    w(0, 0, 0, 0, 0);
    h(0, 1, 0, 0);
    m_clear();
    @(posedge clk);
    #1;
    cyc();
    reset = 1'b0;

    // 4-beat burst, clean
    for (int i = 1; i <= 4; i++) begin
      w(1, 4'd3, 32'h11 * i, 4'hF, i == 4);
      cyc();
    end
    w(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      h(1, 1, 0, 0);
      cyc();
    end
    h(0, 1, 0, 0);
    chk("t1_bvalid", b.BVALID, 1);
    chk("t1_bid", b.BID, 3);
    chk("t1_bresp", b.BRESP, 0);
    b.BREADY = 1'b1;
    cyc();

    // error on beat 2, then clean burst
    for (int i = 1; i <= 4; i++) begin
      w(1, 4'd3, 32'h11 * i, 4'hF, i == 4);
      cyc();
    end
    w(0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      h(1, 1, i == 2, 0);
      cyc();
    end
    h(0, 1, 0, 0);
    chk("t2_bresp_err", b.BRESP, 2'b10);
    cyc();
    for (int i = 1; i <= 4; i++) begin
      w(1, 4'd5, 32'hA0 + i, 4'hF, i == 4);
      cyc();
    end
    w(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      h(1, 1, 0, 0);
      cyc();
    end
    h(0, 1, 0, 0);
    chk("t2_bid", b.BID, 5);
    chk("t2_bresp_ok", b.BRESP, 0);
    cyc();

    // 4 single-beat bursts with B stalled
    b.BREADY = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      w(1, 4'(i), 32'h100 + i, 4'h5, 1);
      cyc();
    end
    w(0, 0, 0, 0, 0);
    chk("t3_cnt", b.burst_cnt, 4);
    chk("t3_wready", b.WREADY, 0);
    for (int i = 0; i < 4; i++) begin
      h(1, 1, 0, 0);
      cyc();
    end
    h(0, 1, 0, 0);
    w(1, 4'd6, 32'h106, 4'hF, 1);
    cyc();
    w(0, 0, 0, 0, 0);
    chk("t3_cnt1", b.burst_cnt, 1);
    chk("t3_wdrdy_respfull", b.wdata_ready, 0);
    b.BREADY = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t3_bid_order", b.BID, i);
      cyc();
    end
    h(1, 1, 0, 0);
    cyc();
    h(0, 1, 0, 0);
    cyc();

    // axi_last and ahb_last together at burst_cnt=2
    w(1, 4'd7, 32'h7, 4'hF, 1);
    cyc();
    w(1, 4'd8, 32'h8, 4'hF, 1);
    cyc();
    chk("t4_cnt_pre", b.burst_cnt, 2);
    w(1, 4'd9, 32'h9, 4'hF, 1);
    h(1, 1, 0, 0);
    cyc();
    w(0, 0, 0, 0, 0);
    h(0, 1, 0, 0);
    chk("t4_cnt_same", b.burst_cnt, 2);
    for (int i = 0; i < 2; i++) begin
      h(1, 1, 0, 0);
      cyc();
    end
    h(0, 1, 0, 0);
    cyc();
    cyc();

    // reset mid-burst with a response and a burst pending
    b.BREADY = 1'b0;
    w(1, 4'd10, 32'hDEAD, 4'hF, 1);
    cyc();
    w(0, 0, 0, 0, 0);
    h(1, 1, 0, 0);
    cyc();
    h(0, 1, 0, 0);
    for (int i = 1; i <= 2; i++) begin
      w(1, 4'd11, 32'hBEE0 + i, 4'hF, 0);
      cyc();
    end
    w(0, 0, 0, 0, 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t5_wready", b.WREADY, 1);
    chk("t5_cnt", b.burst_cnt, 0);
    chk("t5_bvalid", b.BVALID, 0);
    chk("t5_hwdata", b.HWDATA, 0);
    w(1, 4'd2, 32'hABCD, 4'h3, 1);
    cyc();
    w(0, 0, 0, 0, 0);
    chk("t6_hwstrb_nostrb", b2.HWSTRB, 4'hF);
    chk("t6_hwstrb", b.HWSTRB, 4'h3);
    h(1, 1, 0, 0);
    cyc();
    h(0, 1, 0, 0);
    chk("t5_bid", b.BID, 2);
    b.BREADY = 1'b1;
    cyc();

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      w($urandom_range(0, 2) != 0, 4'($urandom), $urandom,
        4'($urandom), $urandom_range(0, 3) == 0);
      h($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
        $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
      b.BREADY = $urandom_range(0, 1);
      reset = (n == 700);
      cyc();
    end
    reset = 1'b0;

    // drain
    w(0, 0, 0, 0, 0);
    b.BREADY = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (lenq.size() == 0 && rq.size() == 0) break;
      h(1, 1, 0, 0);
      cyc();
    end
    h(0, 1, 0, 0);
    cyc();
    chk("drain_cnt", b.burst_cnt, 0);
    chk("drain_bvalid", b.BVALID, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/axi2ahb_wr_buf.md
Name: axi2ahb_wr_buf

Overview:
Parametrised write-path buffer between the AXI W/B channels and the AHB master data phase of the AXI-to-AHB bridge. It buffers write beats and byte strobes and releases them to HWDATA/HWSTRB during AHB data phases. It accumulates AHB errors across a whole burst. It returns one B response per burst, carrying the WID captured when that burst's last beat was accepted. Responses are back-pressured, so a stalled B channel never loses a response.

Parameters:
DATA_BITS, 32, AXI/AHB data width; WSTRB/HWSTRB width is DATA_BITS/8.
ID_BITS, 4, AXI ID width.
FIFO_LINES, 32, data FIFO depth in beats (power of 2, ≥ 2).
CMD_DEPTH, 4, maximum bursts held (ID and response FIFO depth; power of 2).
RESP_SLVERR, 2'b10, BRESP value reported for an errored burst.
STRB_EN, 1, 1 = buffer WSTRB; 0 = HWSTRB tied to all-ones and no strobe storage.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
WID  in  ID_BITS  write ID
WDATA  in  DATA_BITS  write data
WSTRB  in  DATA_BITS/8  byte strobes
WLAST  in  1  last beat of burst
WVALID  in  1  beat valid
WREADY  out  1  beat accepted
BID  out  ID_BITS  response ID
BRESP  out  2  response code
BVALID  out  1  response valid
BREADY  in  1  response accepted
HWDATA  out  DATA_BITS  AHB write data (FIFO head)
HWSTRB  out  DATA_BITS/8  AHB byte strobes (FIFO head)
HREADY  in  1  AHB transfer done
HRESP  in  1  AHB error
cmd_err  in  1  command-level error for the burst in data phase
wdata_phase  in  1  AHB write data phase active
data_last  in  1  current data phase is the burst's last beat
wdata_ready  out  1  at least one complete burst is buffered
burst_cnt  out  log2(CMD_DEPTH)+1  complete bursts buffered

Behaviour:
- Reset (sync, next edge): all FIFOs empty, burst_cnt=0, err_acc=0. Outputs: BVALID=0, wdata_ready=0, HWDATA=0, HWSTRB=0 (or all-ones if STRB_EN=0), BID=0, BRESP=0, WREADY=1. Reset mid-burst discards everything in flight.
- Events:
  - push = WVALID & WREADY
  - axi_last = push & WLAST
  - pop = wdata_phase & HREADY
  - ahb_last = pop & data_last (qualified by HREADY)
- WREADY = ~data_full & (burst_cnt < CMD_DEPTH) & ~id_full. It is combinational and carries no dependency on WVALID.
- Data FIFO width is DATA_BITS (+DATA_BITS/8 if STRB_EN). It pushes on push and pops on pop, and HWDATA/HWSTRB show its head.
- ID FIFO (CMD_DEPTH): pushes WID on axi_last and pops on ahb_last.
- burst_cnt:
  - +1 on axi_last only; -1 on ahb_last only; unchanged when both occur together.
  - Never wraps. Overflow is prevented by WREADY; underflow is a caller protocol error.
- wdata_ready = (burst_cnt != 0) & ~resp_full. The AHB side must not start a burst's data phase while the response FIFO is full.
- Error accumulation (err_acc):
  - Sets on pop & (HRESP | cmd_err).
  - On ahb_last, the response FIFO pushes {resp, id_head}. resp = RESP_SLVERR if (err_acc | HRESP | cmd_err), else 2'b00.
  - err_acc clears on ahb_last, and the clear takes priority over the set in the same cycle.
- Response FIFO (CMD_DEPTH): BVALID = ~resp_empty. It pops on BVALID & BREADY. Once BVALID is high, BID/BRESP hold stable until accepted.
- Simultaneous push and pop on a full data FIFO: not possible, because WREADY is low. Push and pop on an empty data FIFO: pop is a protocol error, since wdata_ready guarantees a full burst is present.
- Latency: a beat accepted in cycle N is at HWDATA from N+1. A response pushed at ahb_last edge N gives BVALID=1 in N+1.
- Single-beat burst (WLAST on first beat) is legal.

Test Plan:
- Reset, then a 4-beat burst WID=3, data 0x11..0x44 with WSTRB=0xF. Then 4 data phases with HREADY=1 and data_last on the 4th → HWDATA sequence 0x11..0x44; wdata_ready=1 from the cycle after WLAST; BVALID=1 one cycle after the 4th pop with BID=3, BRESP=0.
- Same burst with HRESP=1 on beat 2 only → BRESP=2'b10; a following clean burst WID=5 → BRESP=0, BID=5 (err_acc cleared).
- Write 4 single-beat bursts WID=1..4 with BREADY=0 → burst_cnt=4, WREADY=0. Drain all on AHB → BIDs 1,2,3,4 in order; wdata_ready=0 while the response FIFO is full.
- axi_last and ahb_last in the same cycle with burst_cnt=2 → burst_cnt stays 2.
- Assert reset mid-burst after 2 of 4 beats → next cycle WREADY=1, burst_cnt=0, BVALID=0, HWDATA=0; a new 1-beat burst then completes normally.
- STRB_EN=0 with WSTRB=0x3 → HWSTRB=0xF throughout.
